// File: rtl/cpu_mem_pkg.sv
// Shared memory-side types and constants for the CPU core's SRAM path.
// Used by sram_port_arbiter and arb_grant_sel (see SRAM_ARB_RR_EN there).
package cpu_mem_pkg;

  localparam int unsigned MEM_ADDR_W   = 32;
  localparam int unsigned MEM_DATA_W   = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  // Fetch address after reset; benches use it as the base fetch address.
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } resp_owner_t;

  typedef struct packed {
    logic inst;
    logic data;
  } grant_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Pure grant decision between the fetch and load/store requesters.
// `define SRAM_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation guard.
module arb_grant_sel
  import cpu_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    inst_req,
  input  logic                    data_req,
  input  resp_owner_t             last_grant,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output grant_t                  grant
);

`ifdef SRAM_ARB_RR_EN
  logic unused_starve_cnt;
  assign unused_starve_cnt = ^starve_cnt;

  always_comb begin
    grant = '0;
    if (inst_req && data_req) begin
      if (last_grant == INST) begin
        grant.data = 1'b1;
      end else begin
        grant.inst = 1'b1;
      end
    end else begin
      grant.inst = inst_req;
      grant.data = data_req;
    end
  end
`else
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic unused_last_grant;
  logic starved;

  assign unused_last_grant = ^last_grant;
  assign starved           = inst_req && (starve_cnt == STARVE_LIM);

  always_comb begin
    grant = '0;
    if (starved) begin
      grant.inst = 1'b1;
    end else if (data_req) begin
      grant.data = 1'b1;
    end else if (inst_req) begin
      grant.inst = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch and load/store, one access per cycle.
// `define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (data first).
module sram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,

  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,

  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  resp_owner_t             resp_owner, resp_owner_nxt;
  resp_owner_t             last_grant, last_grant_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  logic   inst_req_live;
  logic   data_req_live;
  grant_t grant;

  // Requests are masked while reset is high so no access reaches the SRAM.
  assign inst_req_live = inst_req && !reset;
  assign data_req_live = data_req && !reset;

  arb_grant_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant_sel (
    .inst_req   (inst_req_live),
    .data_req   (data_req_live),
    .last_grant (last_grant),
    .starve_cnt (starve_cnt),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner <= NONE;
      last_grant <= INST;
      starve_cnt <= '0;
    end else begin
      resp_owner <= resp_owner_nxt;
      last_grant <= last_grant_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    resp_owner_nxt = NONE;
    last_grant_nxt = last_grant;
    if (grant.data) begin
      resp_owner_nxt = DATA;
      last_grant_nxt = DATA;
    end else if (grant.inst) begin
      resp_owner_nxt = INST;
      last_grant_nxt = INST;
    end
  end

`ifdef SRAM_ARB_RR_EN
  assign starve_cnt_nxt = '0;
`else
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!inst_req || grant.inst) begin
      starve_cnt_nxt = '0;
    end else if (grant.data && (starve_cnt != STARVE_LIM)) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end
`endif

  // data_ok is masked by reset so a response in flight when reset arrives is dropped at once.
  always_comb begin
    inst_addr_ok = grant.inst;
    data_addr_ok = grant.data;
    sram_en      = grant.inst | grant.data;
    sram_addr    = grant.data ? data_addr : inst_addr;
    sram_wdata   = grant.data ? data_wdata : '0;
    sram_we      = (grant.data && data_wr) ? data_wstrb : '0;
    inst_data_ok = !reset && (resp_owner == INST);
    data_data_ok = !reset && (resp_owner == DATA);
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
  end

endmodule
